// File: rtl/disk_transfer_ctrl.sv
// Disk <-> memory block copier that also arbitrates the single disk port against direct CPU accesses.
// Latency: done pulses 1+3*length cycles after start is accepted (1 cycle for error or zero length).
// Backpressure: the CPU is stalled (cpu_stall_o) whenever it requests the disk while a transfer owns it.
module disk_transfer_ctrl #(
  parameter int unsigned DISK_SIZE = 100,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [31:0] disk_base_i,
  input  logic [31:0] mem_base_i,
  input  logic [31:0] length_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  input  logic        cpu_disk_req_i,
  input  logic        cpu_disk_we_i,
  input  logic [31:0] cpu_disk_addr_i,
  input  logic [31:0] cpu_disk_wdata_i,
  output logic        cpu_stall_o,
  output logic        disk_we_o,
  output logic [31:0] disk_addr_o,
  output logic [31:0] disk_wdata_o,
  input  logic [31:0] disk_rdata_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        dir_q, dir_d;       // 0: disk->mem, 1: mem->disk
  logic        xfer_q, xfer_d;     // current FINISH follows real word copies
  logic        error_q, error_d;
  logic [31:0] disk_ptr_q, disk_ptr_d;
  logic [31:0] mem_ptr_q, mem_ptr_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] buf_q, buf_d;

  // Range check in 33 bits so a base+length wrap is seen as out of range.
  logic [32:0] disk_end, mem_end;
  logic        range_bad;

  assign disk_end  = {1'b0, disk_base_i} + {1'b0, length_i};
  assign mem_end   = {1'b0, mem_base_i} + {1'b0, length_i};
  assign range_bad = (length_i != 32'd0) &&
                     ((disk_end > 33'(DISK_SIZE)) || (mem_end > 33'(MEM_SIZE)));

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      xfer_q     <= 1'b0;
      error_q    <= 1'b0;
      disk_ptr_q <= 32'd0;
      mem_ptr_q  <= 32'd0;
      remain_q   <= 32'd0;
      buf_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      xfer_q     <= xfer_d;
      error_q    <= error_d;
      disk_ptr_q <= disk_ptr_d;
      mem_ptr_q  <= mem_ptr_d;
      remain_q   <= remain_d;
      buf_q      <= buf_d;
    end
  end

  // Next-state: accept a request in IDLE, then READ/WAIT/WRITE per word until the count runs out.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    xfer_d     = xfer_q;
    error_d    = error_q;
    disk_ptr_d = disk_ptr_q;
    mem_ptr_d  = mem_ptr_q;
    remain_d   = remain_q;
    buf_d      = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dir_d      = dir_i;
          disk_ptr_d = disk_base_i;
          mem_ptr_d  = mem_base_i;
          remain_d   = length_i;
          error_d    = range_bad;
          if (range_bad || (length_i == 32'd0)) begin
            xfer_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            xfer_d  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        // Source data is valid by the edge that closes the cycle the address was held.
        buf_d   = dir_q ? mem_rdata_i : disk_rdata_i;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        disk_ptr_d = disk_ptr_q + 32'd1;
        mem_ptr_d  = mem_ptr_q + 32'd1;
        remain_d   = remain_q - 32'd1;
        state_d    = (remain_q > 32'd1) ? S_READ : S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Port muxing: CPU owns the disk in IDLE, the copy engine everywhere else.
  always_comb begin
    busy_o       = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE) ||
                   ((state_q == S_FINISH) && xfer_q);
    done_o       = (state_q == S_FINISH);
    error_o      = error_q;
    cpu_stall_o  = cpu_disk_req_i && (state_q != S_IDLE);
    mem_we_o     = (state_q == S_WRITE) && !dir_q;
    mem_addr_o   = mem_ptr_q;
    mem_wdata_o  = buf_q;
    disk_we_o    = (state_q == S_WRITE) && dir_q;
    disk_addr_o  = disk_ptr_q;
    disk_wdata_o = buf_q;
    if (state_q == S_IDLE) begin
      // Gate with reset so a CPU write cannot slip through while the block is held in reset.
      disk_we_o    = rst_ni && cpu_disk_req_i && cpu_disk_we_i;
      disk_addr_o  = cpu_disk_addr_i;
      disk_wdata_o = cpu_disk_wdata_i;
    end
  end

endmodule
